// File: rtl/router_pkg.sv
// Shared router definitions: header field positions, default FIFO geometry and
// the destination address encoding used by the synchronizer, FSM and FIFOs.
package router_pkg;

  localparam int FIFO_DEPTH   = 16;
  localparam int BYTE_W       = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int PKT_CNT_W    = 7;

  typedef enum logic [1:0] {
    DEST_0 = 2'd0,
    DEST_1 = 2'd1,
    DEST_2 = 2'd2
  } router_addr_e;

  // Bytes still to come after a header: the payload plus the trailing parity byte.
  function automatic logic [PKT_CNT_W-1:0] pkt_reload(
    input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len
  );
    return {1'b0, len} + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage for router_fifo: DEPTH x (WIDTH+1) register array with a
// synchronous write port and a registered read port that returns 0 when idle.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [WIDTH:0] wr_entry_i,
  input  logic           rd_en_i,
  input  logic [AW-1:0]  rd_addr_i,
  output logic [WIDTH:0] rd_entry_o,
  output logic [WIDTH-1:0] rd_data_q
);

  logic [WIDTH:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_entry_i;
    end
  end

  // The owner needs the entry at the read edge itself to update its packet counter.
  assign rd_entry_o = mem_q[rd_addr_i];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_entry_o[WIDTH-1:0];
    end else begin
      rd_data_q <= '0;
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: wrap-bit pointers, full/empty flags, header
// tagging on write and a remaining-byte counter driven by the read side.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH:0]       rd_entry;
  logic                 do_wr, do_rd;
  logic                 unused_addr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Soft reset wins over both ports so a flush never leaves a half-accepted byte.
  assign do_wr = write_enb && !full  && !soft_reset;
  assign do_rd = read_enb  && !empty && !soft_reset;

  assign pkt_active  = (pkt_cnt_q != '0);
  assign unused_addr = ^rd_entry[HDR_ADDR_MSB:HDR_ADDR_LSB];

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk        (clock),
    .rst_n      (resetn),
    .wr_en_i    (do_wr),
    .wr_addr_i  (wr_ptr_q[AW-1:0]),
    .wr_entry_i ({lfd_state, data_in}),
    .rd_en_i    (do_rd),
    .rd_addr_i  (rd_ptr_q[AW-1:0]),
    .rd_entry_o (rd_entry),
    .rd_data_q  (data_out)
  );

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (soft_reset) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pkt_cnt_d = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (rd_entry[WIDTH]) begin
          pkt_cnt_d = pkt_reload(rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_router_fifo;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_active;

  router_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_active (pkt_active)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: an ordered list of stored {header, byte} entries, the
  // number of packet bytes still expected, and the byte last presented.
  logic [WIDTH:0]   mq[$];
  int               m_cnt;
  logic [WIDTH-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ":data_out"},   32'(data_out),       32'(m_dout));
    check({phase, ":empty"},      32'(empty),          32'(mq.size() == 0));
    check({phase, ":full"},       32'(full),           32'(mq.size() == DEPTH));
    check({phase, ":pkt_active"}, 32'(pkt_active),     32'(m_cnt != 0));
    check({phase, ":pkt_cnt"},    32'(dut.pkt_cnt_q),  32'(m_cnt));
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt  = 0;
    m_dout = '0;
  endtask

  // One clock cycle: drive inputs after a falling edge, predict, check at the next falling edge.
  task automatic step(input string phase, input logic we, input logic re, input logic lfd,
                      input logic [WIDTH-1:0] din, input logic sr);
    logic           was_full;
    logic           was_empty;
    logic [WIDTH:0] e;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    was_full   = (mq.size() == DEPTH);
    was_empty  = (mq.size() == 0);
    @(posedge clock);
    if (sr) begin
      model_reset();
    end else begin
      if (re && !was_empty) begin
        e      = mq.pop_front();
        m_dout = e[WIDTH-1:0];
        if (e[WIDTH]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else begin
        m_dout = '0;
      end
      if (we && !was_full) mq.push_back({lfd, din});
    end
    @(negedge clock);
    cyc++;
    check_outputs(phase);
  endtask

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");
    resetn = 1'b1;

    // Header 0x14 (length 5) plus six bytes, then read the whole packet back.
    step("pkt_wr", 1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 6; i++) step("pkt_wr", 1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) step("pkt_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("pkt_done:pkt_active", 32'(pkt_active), 32'(0));
    step("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Overfill: the 17th write must be dropped; drain plus one read on empty.
    for (int i = 0; i < 17; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 17; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Read+write while full: read proceeds, 0x55 is dropped.
    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 1'b0, 1'b0, 8'h20 + 8'(i), 1'b0);
    step("full_rw", 1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Read+write while empty: write proceeds, read ignored.
    step("empty_rw", 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    step("empty_rw_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Interleaved traffic carrying both pointers across the wrap.
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'(i % 2), 1'b0, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) step("wrap_drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Soft reset mid-packet with a concurrent write.
    step("sr_wr", 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 4; i++) step("sr_wr", 1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), 1'b0);
    step("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step("soft_reset", 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
    step("sr_after", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Hard reset between edges while a packet is active and data_out is non-zero.
    step("hr_wr", 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
    step("hr_wr", 1'b1, 1'b0, 1'b0, 8'hD1, 1'b0);
    step("hr_wr", 1'b1, 1'b0, 1'b0, 8'hD2, 1'b0);
    step("hr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    write_enb = 1'b0;
    read_enb  = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("hard_reset");
    @(negedge clock);
    check_outputs("hard_reset_held");
    resetn = 1'b1;

    // Random traffic including headers and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step("random",
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 15),
           8'($urandom),
           1'($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
